// File: rtl/sipo_ctrl_pkg.sv
// Shared types and constants for the serial-in/parallel-out frame controller.
package sipo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic PAR_EVEN = 1'b0;

endpackage

// File: rtl/sipo_shift_en.sv
// Enabled shift register: shifts in at bit 0 and exposes the whole parallel word.
module sipo_shift_en #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    // Clear takes priority so a new frame always starts from zero.
    if (clr_i) begin
      shift_d = '0;
    end else if (en_i) begin
      shift_d = {shift_q[Width-2:0], d_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q_o = shift_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: start detection, bit counting, optional even-parity check and a
// one-entry valid/ready output buffer around an enabled SIPO shift register.
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          PARITY_EN = 1'b1,
  parameter int unsigned CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             start,
  input  logic             bit_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_par_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              perr_q, perr_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_par_err_q, out_par_err_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic              sh_clr, sh_en, load;
  logic [WIDTH-1:0]  shift_word;

  sipo_shift_en #(
    .Width(WIDTH)
  ) u_shift (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (sh_clr),
    .en_i   (sh_en),
    .d_i    (ser_in),
    .q_o    (shift_word)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    perr_d        = perr_q;
    sh_clr        = 1'b0;
    sh_en         = 1'b0;
    load          = 1'b0;
    overrun_d     = 1'b0;
    out_data_d    = out_data_q;
    out_par_err_d = out_par_err_q;
    out_valid_d   = out_valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          perr_d  = 1'b0;
          sh_clr  = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          sh_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = PARITY_EN ? PARITY : DONE;
          end
        end
      end
      PARITY: begin
        if (bit_en) begin
          perr_d  = PARITY_EN ? ((^shift_word) ^ ser_in ^ PAR_EVEN) : 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d   = IDLE;
        // A consumer draining the buffer this cycle frees room for the new word.
        load      = !out_valid_q || out_ready;
        overrun_d = !load;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_data_d    = shift_word;
      out_par_err_d = perr_q;
      out_valid_d   = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      perr_q        <= 1'b0;
      out_data_q    <= '0;
      out_par_err_q <= 1'b0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      perr_q        <= perr_d;
      out_data_q    <= out_data_d;
      out_par_err_q <= out_par_err_d;
      out_valid_q   <= out_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_par_err = out_par_err_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl (WIDTH=8, PARITY_EN=1) with hand-computed expectations.
module tb_sipo_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_in = 1'b0;
  logic       start = 1'b0;
  logic       bit_en = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_par_err;
  logic       out_valid;
  logic       busy;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  sipo_frame_ctrl #(
    .WIDTH     (8),
    .PARITY_EN (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ser_in      (ser_in),
    .start       (start),
    .bit_en      (bit_en),
    .out_data    (out_data),
    .out_par_err (out_par_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_in = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask

  // Start pulse, 8 data bits MSB first, then the parity bit; ends in the DONE cycle.
  task automatic send_frame(input logic [7:0] w, input logic p);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    send_bit(p);
  endtask

  initial begin
    logic [7:0] w;
    #12;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: good parity, consumer always ready
    out_ready = 1'b1;
    send_frame(8'hA5, 1'b0);
    check_eq("t1_done_busy", 32'(busy), 32'd1);
    check_eq("t1_done_valid", 32'(out_valid), 32'd0);
    tick();
    check_eq("t1_valid", 32'(out_valid), 32'd1);
    check_eq("t1_data", 32'(out_data), 32'hA5);
    check_eq("t1_perr", 32'(out_par_err), 32'd0);
    check_eq("t1_idle_busy", 32'(busy), 32'd0);
    tick();
    check_eq("t1_valid_drop", 32'(out_valid), 32'd0);

    // 2: bad parity is still delivered
    send_frame(8'hA5, 1'b1);
    tick();
    check_eq("t2_valid", 32'(out_valid), 32'd1);
    check_eq("t2_data", 32'(out_data), 32'hA5);
    check_eq("t2_perr", 32'(out_par_err), 32'd1);
    tick();

    // 3: sparse strobes, bit_en in IDLE and start mid-frame are ignored
    send_bit(1'b0);
    check_eq("t3_idle_bit_busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t3_busy_after_start", 32'(busy), 32'd1);
    w = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      tick();
      if (i == 4) start = 1'b1;
      tick();
      start = 1'b0;
      send_bit(w[i]);
      check_eq("t3_busy_mid", 32'(busy), 32'd1);
    end
    tick();
    tick();
    send_bit(1'b0);
    check_eq("t3_done_busy", 32'(busy), 32'd1);
    tick();
    check_eq("t3_valid", 32'(out_valid), 32'd1);
    check_eq("t3_data", 32'(out_data), 32'hA5);
    check_eq("t3_perr", 32'(out_par_err), 32'd0);
    check_eq("t3_end_busy", 32'(busy), 32'd0);
    tick();

    // 4: buffer full -> second frame dropped with a one-cycle overrun pulse
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    tick();
    check_eq("t4_valid1", 32'(out_valid), 32'd1);
    check_eq("t4_data1", 32'(out_data), 32'h3C);
    send_frame(8'hC3, 1'b0);
    check_eq("t4_no_early_ovr", 32'(overrun), 32'd0);
    tick();
    check_eq("t4_overrun", 32'(overrun), 32'd1);
    check_eq("t4_data_held", 32'(out_data), 32'h3C);
    check_eq("t4_valid_held", 32'(out_valid), 32'd1);
    tick();
    check_eq("t4_overrun_end", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    tick();
    check_eq("t4_drained", 32'(out_valid), 32'd0);
    tick();

    // 5: handover in the DONE cycle
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0);
    tick();
    check_eq("t5_data1", 32'(out_data), 32'h11);
    send_frame(8'h22, 1'b0);
    check_eq("t5_held_valid", 32'(out_valid), 32'd1);
    check_eq("t5_held_data", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    tick();
    check_eq("t5_valid2", 32'(out_valid), 32'd1);
    check_eq("t5_data2", 32'(out_data), 32'h22);
    check_eq("t5_no_overrun", 32'(overrun), 32'd0);
    tick();
    check_eq("t5_drained", 32'(out_valid), 32'd0);
    check_eq("t5_no_overrun2", 32'(overrun), 32'd0);

    // 6: reset mid-frame, then a clean frame
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_data", 32'(out_data), 32'h0);
    check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t6_rst_perr", 32'(out_par_err), 32'd0);
    check_eq("t6_rst_overrun", 32'(overrun), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    send_frame(8'h5A, 1'b0);
    tick();
    check_eq("t6_valid", 32'(out_valid), 32'd1);
    check_eq("t6_data", 32'(out_data), 32'h5A);
    check_eq("t6_perr", 32'(out_par_err), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
Frame controller for the serial-in/parallel-out datapath. It detects a frame start, gates shifting of WIDTH serial bits into an internal enabled SIPO register, and optionally checks a trailing even-parity bit. The completed word is delivered on a one-entry valid/ready output buffer. The block sits between a bit-rate strobe source and any parallel word consumer.

Parameters:
WIDTH, 8, data bits per frame (2..32)
PARITY_EN, 1, 1 = one even-parity bit follows the data bits; 0 = no parity bit
CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset; clk and rst_n are the block's only clock and reset
ser_in  in  1  serial data bit, sampled only when bit_en=1
start  in  1  frame-start request, sampled only in IDLE
bit_en  in  1  bit strobe: one serial bit is valid this cycle
out_data  out  WIDTH  received word; the first bit received is the MSB
out_par_err  out  1  parity error flag qualified by out_valid; 0 when PARITY_EN=0
out_valid  out  1  output buffer holds a word
out_ready  in  1  consumer accepts the word
busy  out  1  state != IDLE
overrun  out  1  one-cycle pulse: a completed frame was dropped because the buffer was full

Behaviour:
- Reset, asynchronous and active-low: state=IDLE; counter, shift register, out_data, out_par_err, out_valid and overrun all go to 0. A partial frame in progress is discarded. After reset deasserts, operation resumes from IDLE.
- States: IDLE, SHIFT, PARITY, DONE.
- IDLE:
  - start=1 -> SHIFT. The counter and shift register clear on the same edge.
  - bit_en is ignored in IDLE.
- SHIFT:
  - On each bit_en=1: shift_reg <= {shift_reg[WIDTH-2:0], ser_in} and cnt++.
  - On the bit_en with cnt==WIDTH-1: go to PARITY if PARITY_EN=1, else go to DONE.
  - With bit_en=0 the state holds; there is no timeout.
  - start is ignored outside IDLE.
- PARITY:
  - On bit_en=1: perr <= (^shift_reg) ^ ser_in, then go to DONE.
- DONE (exactly one cycle, then IDLE):
  - If out_valid=0, or out_valid=1 with out_ready=1 in this same cycle: load out_data <= shift_reg and out_par_err <= perr, and set out_valid=1.
  - Otherwise the new frame is dropped, the held word is unchanged, and overrun=1 for the next cycle only.
- Output handshake:
  - A transfer occurs on any cycle with out_valid and out_ready both high.
  - On a transfer with no load that cycle, out_valid clears on the next edge.
  - out_data and out_par_err stay stable while out_valid=1 and no transfer occurs.
  - out_ready is a don't-care while out_valid=0.
- Latency: the edge that samples the final bit (data bit, or parity bit) enters DONE; out_valid rises on the following edge, 2 clocks after the final-bit cycle.
- start in the DONE cycle is ignored; start in the first IDLE cycle after DONE is accepted. The minimum inter-frame gap is therefore 1 IDLE cycle.
- Frames with a parity error are still delivered, with out_par_err=1.
- busy=1 in SHIFT, PARITY and DONE.

Decomposition:
- Package sipo_ctrl_pkg:
  - state enum: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2, DONE=2'd3
  - localparam for the parity sense (EVEN=0)
- Sub-module sipo_shift_en: WIDTH-bit shift register with async active-low reset, synchronous clear, and shift enable. It shifts in at bit 0 and exposes the full parallel word.
- FSM, counter, parity check and output buffer live in sipo_frame_ctrl.

Test Plan:
1. WIDTH=8, PARITY_EN=1: start, then bits 1,0,1,0,0,1,0,1 plus parity 0 on consecutive bit_en, out_ready=1 -> out_valid high 2 clocks after the parity bit; out_data=0xA5, out_par_err=0; out_valid drops the next cycle.
2. Same frame with parity bit 1 -> out_data=0xA5, out_par_err=1.
3. bit_en every 3rd cycle, with start pulsed mid-frame and bit_en pulsed in IDLE -> frame unaffected, out_data=0xA5; busy high from the edge after start until the DONE cycle ends.
4. out_ready=0: receive 0x3C, then 0xC3 -> overrun pulses for exactly 1 cycle; out_data stays 0x3C. Raise out_ready -> one transfer, then out_valid=0.
5. Back-to-back: frame 0x11 delivered; out_ready asserted in the DONE cycle of frame 0x22 -> both transfers occur, no overrun, out_valid stays high across the handover.
6. rst_n asserted after 4 bits of a frame -> all outputs 0 immediately. A new frame 0x5A after release is received correctly.
